scan_phase_ctrl: RTL and testbench
==================================

// Module: scan_phase_ctrl
// PURPOSE
//  Top-level phase sequencer for one scan job: UART load -> frame parse -> DA/acq/ccd run -> done.
//  Owns port A of the shared parameter/waveform BRAM: selects the address source, gates the write
//  enable and routes registered read data to the frame analyzer or the DA generator.
//  Replaces the ad-hoc load-timeout counter, proc_begin flag and 3-way completion counter in top.
// PARAMETERS
//  ADDR_W        14          BRAM port-A address width
//  DATA_W        16          BRAM port-A read data width
//  LOAD_TIMEOUT  10000       rx-silent cycles that end the LOAD phase (>=2)
//  RUN_WDOG      100000000   max cycles in PARSE+RUN before forced abort; 0 disables
// PORTS
//  sys_clk      in   1       system clock (50 MHz)
//  sys_rst_n    in   1       asynchronous active-low reset
//  rx_done      in   1       UART byte-received strobe
//  wr_en        in   1       write request from BRAM writer
//  wr_addr      in   ADDR_W  writer address
//  frame_addr   in   ADDR_W  frame analyzer read address
//  gen_addr     in   ADDR_W  DA generator x read address
//  frame_done   in   1       analyzer done pulse (parameters valid)
//  da_done      in   1       DA generator finished pulse
//  acq_done     in   1       acq generator finished pulse
//  ccd_done     in   1       ccd generator finished pulse
//  abort        in   1       software abort pulse
//  ram_douta    in   DATA_W  BRAM port-A read data (1-cycle latency)
//  ram_we       out  1       BRAM port-A write enable
//  ram_addra    out  ADDR_W  BRAM port-A address
//  frame_rdata  out  DATA_W  registered read data for analyzer
//  gen_rdata    out  DATA_W  registered read data for DA generator
//  load_done    out  1       level: load complete (analyzer data_rdy)
//  run_start    out  1       1-cycle pulse: start all three generators
//  proc_end     out  1       1-cycle pulse: job ended (resets writer)
//  phase        out  3       current phase code
//  wdog_err     out  1       sticky: watchdog fired; cleared on next IDLE->LOAD
// BEHAVIOUR
//  Reset: phase=IDLE(0); all outputs 0; counters, done flags, read registers cleared.
//  Phases: IDLE=0, LOAD=1, PARSE=2, RUN=3, DONE=4; registered state, outputs registered.
//  IDLE : ram_addra=wr_addr, ram_we=wr_en. rx_done -> LOAD, silence counter=0, wdog_err<=0.
//  LOAD : ram_addra=wr_addr, ram_we=wr_en. rx_done clears silence counter; otherwise +1.
//         counter==LOAD_TIMEOUT-1 with no rx_done that cycle -> PARSE, load_done<=1.
//  PARSE: ram_we=0, ram_addra=frame_addr, frame_rdata<=ram_douta every cycle.
//         frame_done -> RUN; run_start=1 for exactly the first RUN cycle.
//  RUN  : ram_we=0, ram_addra=gen_addr, gen_rdata<=ram_douta every cycle.
//         da/acq/ccd_done set sticky flags; any order, any number same cycle.
//         All three flags set (incl. flag completing this cycle) -> DONE.
//  DONE : one cycle; proc_end=1, load_done<=0, flags cleared -> IDLE.
//  Read data: consumer sees word 2 cycles after presenting address (BRAM + register).
//  frame_rdata/gen_rdata hold last value outside their phase.
//  rx_done in PARSE/RUN/DONE ignored; ram_we forced 0 outside IDLE/LOAD regardless of wr_en.
//  Watchdog: counts cycles in PARSE+RUN; reaching RUN_WDOG -> wdog_err<=1, go DONE.
//  abort: any non-IDLE phase -> DONE next cycle (proc_end pulse); in IDLE ignored.
//  abort and normal exit same cycle: single DONE, single proc_end.
//  Duplicate done pulse on one generator: idempotent (flag stays 1).
//  Reset mid-job: immediate return to IDLE, no proc_end pulse.
//  Counter widths: silence $clog2(LOAD_TIMEOUT)+1, wdog 32 bit, no wrap (saturate at terminal).
// STRUCTURE
//  scan_pkg: phase code localparams (PH_IDLE..PH_DONE), PHASE_W=3, default widths.
//  Sub-module done_collector: 3 sticky flags, clear input, all_done combinational out.
//  Address/we mux and read-data registers stay in scan_phase_ctrl.
// TESTING
//  Reset, 5 rx_done pulses 100 cycles apart, then silence -> load_done=1 exactly 10000 cycles after last rx_done.
//  PARSE, frame_addr=0x0010, douta=0xBEEF -> frame_rdata=0xBEEF 1 cycle after douta; ram_we=0 with wr_en=1.
//  frame_done -> run_start single pulse; done pulses ccd@t, da@t+50, acq@t+50 -> DONE at t+51, proc_end 1 cycle.
//  RUN_WDOG=1000, no done pulses -> wdog_err=1, proc_end after 1000 PARSE+RUN cycles, phase back to 0.
//  abort in RUN coincident with last done -> exactly one proc_end, phase 4 then 0.
//  sys_rst_n low mid-RUN -> all outputs 0 asynchronously, phase=0, no proc_end pulse.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared phase encoding and default widths for the scan job sequencer.
package scan_pkg;

    localparam int unsigned PHASE_W    = 3;
    localparam int unsigned ADDR_W_DEF = 14;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned N_GEN      = 3;

    typedef enum logic [PHASE_W-1:0] {
        PH_IDLE  = 3'd0,
        PH_LOAD  = 3'd1,
        PH_PARSE = 3'd2,
        PH_RUN   = 3'd3,
        PH_DONE  = 3'd4
    } phase_e;

    // True while the job is being processed (watchdog window).
    function automatic logic in_proc(input phase_e p);
        return (p == PH_PARSE) || (p == PH_RUN);
    endfunction

endpackage

// File: rtl/scan_phase_ctrl_done_collector.sv
// Sticky completion flags for the three generators; all_done includes pulses
// arriving in the current cycle so the sequencer can leave RUN without delay.
module done_collector
    import scan_pkg::*;
(
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic enable,
    input  logic clear,
    input  logic da_done,
    input  logic acq_done,
    input  logic ccd_done,
    output logic all_done
);

    logic [N_GEN-1:0] flags;
    logic [N_GEN-1:0] hits;

    always_comb begin
        hits     = enable ? {ccd_done, acq_done, da_done} : '0;
        all_done = enable && (&(flags | hits));
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            flags <= '0;
        end else if (clear) begin
            flags <= '0;
        end else begin
            flags <= flags | hits;
        end
    end

endmodule

// File: rtl/scan_phase_ctrl.sv
// Phase sequencer for one scan job: load -> parse -> run -> done.
// Owns BRAM port A: address/we selection and per-consumer read data registers.
module scan_phase_ctrl
    import scan_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned LOAD_TIMEOUT = 10000,
    parameter int unsigned RUN_WDOG     = 100000000
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 rx_done,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [ADDR_W-1:0]    frame_addr,
    input  logic [ADDR_W-1:0]    gen_addr,
    input  logic                 frame_done,
    input  logic                 da_done,
    input  logic                 acq_done,
    input  logic                 ccd_done,
    input  logic                 abort,
    input  logic [DATA_W-1:0]    ram_douta,
    output logic                 ram_we,
    output logic [ADDR_W-1:0]    ram_addra,
    output logic [DATA_W-1:0]    frame_rdata,
    output logic [DATA_W-1:0]    gen_rdata,
    output logic                 load_done,
    output logic                 run_start,
    output logic                 proc_end,
    output logic [PHASE_W-1:0]   phase,
    output logic                 wdog_err
);

    localparam int unsigned        SIL_W      = $clog2(LOAD_TIMEOUT) + 1;
    localparam logic [SIL_W-1:0]   SIL_LAST   = SIL_W'(LOAD_TIMEOUT - 1);
    localparam logic [31:0]        WDOG_LAST  = 32'(RUN_WDOG - 1);

    phase_e            state;
    phase_e            state_nxt;
    logic [SIL_W-1:0]  sil_cnt;
    logic [31:0]       wdog_cnt;
    logic              wdog_hit;
    logic              all_done;

    done_collector u_done_collector (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .enable    (state == PH_RUN),
        .clear     (state == PH_DONE),
        .da_done   (da_done),
        .acq_done  (acq_done),
        .ccd_done  (ccd_done),
        .all_done  (all_done)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= PH_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wdog_hit  = (RUN_WDOG != 0) && in_proc(state) && (wdog_cnt == WDOG_LAST);
        case (state)
            PH_IDLE:  if (rx_done) state_nxt = PH_LOAD;
            PH_LOAD: begin
                if (abort)                                state_nxt = PH_DONE;
                else if (!rx_done && sil_cnt == SIL_LAST) state_nxt = PH_PARSE;
            end
            PH_PARSE: begin
                if (abort || wdog_hit) state_nxt = PH_DONE;
                else if (frame_done)   state_nxt = PH_RUN;
            end
            PH_RUN:   if (abort || wdog_hit || all_done) state_nxt = PH_DONE;
            // DONE always lasts one cycle, so a late abort cannot repeat proc_end.
            PH_DONE:  state_nxt = PH_IDLE;
            default:  state_nxt = PH_IDLE;
        endcase
    end

    always_comb begin
        phase     = state;
        ram_we    = 1'b0;
        ram_addra = wr_addr;
        case (state)
            PH_IDLE, PH_LOAD: ram_we    = wr_en;
            PH_PARSE:         ram_addra = frame_addr;
            PH_RUN:           ram_addra = gen_addr;
            default:          ;
        endcase
        if (!sys_rst_n) begin
            ram_we    = 1'b0;
            ram_addra = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sil_cnt     <= '0;
            wdog_cnt    <= '0;
            load_done   <= 1'b0;
            run_start   <= 1'b0;
            proc_end    <= 1'b0;
            wdog_err    <= 1'b0;
            frame_rdata <= '0;
            gen_rdata   <= '0;
        end else begin
            if (state != PH_LOAD || rx_done) begin
                sil_cnt <= '0;
            end else if (sil_cnt != SIL_LAST) begin
                sil_cnt <= sil_cnt + SIL_W'(1);
            end

            if (!in_proc(state)) begin
                wdog_cnt <= '0;
            end else if (wdog_cnt != '1) begin
                wdog_cnt <= wdog_cnt + 32'd1;
            end

            if (state == PH_LOAD && state_nxt == PH_PARSE) begin
                load_done <= 1'b1;
            end else if (state == PH_DONE) begin
                load_done <= 1'b0;
            end

            if (state == PH_IDLE && state_nxt == PH_LOAD) begin
                wdog_err <= 1'b0;
            end else if (wdog_hit) begin
                wdog_err <= 1'b1;
            end

            run_start <= (state == PH_PARSE) && (state_nxt == PH_RUN);
            proc_end  <= (state != PH_DONE) && (state_nxt == PH_DONE);

            if (state == PH_PARSE) frame_rdata <= ram_douta;
            if (state == PH_RUN)   gen_rdata   <= ram_douta;
        end
    end

endmodule

// File: tb/tb_scan_phase_ctrl.sv
// Randomized bench for scan_phase_ctrl against an event/time-based job model.
module tb_scan_phase_ctrl;
    import scan_pkg::*;

    localparam int unsigned AW = 14;
    localparam int unsigned DW = 16;
    localparam int unsigned LT = 10000;
    localparam int unsigned WD = 1000;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          rx_done = 1'b0, wr_en = 1'b0, frame_done = 1'b0;
    logic          da_done = 1'b0, acq_done = 1'b0, ccd_done = 1'b0, abort = 1'b0;
    logic [AW-1:0] wr_addr = '0, frame_addr = '0, gen_addr = '0;
    logic [DW-1:0] ram_douta = '0;
    logic          ram_we, load_done, run_start, proc_end, wdog_err;
    logic [AW-1:0] ram_addra;
    logic [DW-1:0] frame_rdata, gen_rdata;
    logic [PHASE_W-1:0] phase;

    always #5 sys_clk = ~sys_clk;

    scan_phase_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .LOAD_TIMEOUT(LT), .RUN_WDOG(WD)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_done(rx_done), .wr_en(wr_en),
        .wr_addr(wr_addr), .frame_addr(frame_addr), .gen_addr(gen_addr),
        .frame_done(frame_done), .da_done(da_done), .acq_done(acq_done),
        .ccd_done(ccd_done), .abort(abort), .ram_douta(ram_douta), .ram_we(ram_we),
        .ram_addra(ram_addra), .frame_rdata(frame_rdata), .gen_rdata(gen_rdata),
        .load_done(load_done), .run_start(run_start), .proc_end(proc_end),
        .phase(phase), .wdog_err(wdog_err)
    );

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Job model: LOAD ends a fixed time after the last byte, the watchdog
    // measures time since the job entered PARSE, completion is a set of seen generators.
    longint     cyc = 0;
    longint     m_last_rx, m_job_start;
    int         m_phase;
    bit         m_load_done, m_run_start, m_proc_end, m_wdog_err;
    bit [2:0]   m_got;
    logic [DW-1:0] m_frame, m_gen;
    bit         hold_data = 1'b0;

    task automatic model_reset();
        m_phase = 0; m_load_done = 0; m_run_start = 0; m_proc_end = 0;
        m_wdog_err = 0; m_got = '0; m_frame = '0; m_gen = '0;
        m_last_rx = 0; m_job_start = 0;
    endtask

    task automatic model_step();
        int  np;
        bit  wd;
        cyc++;
        if (!sys_rst_n) begin
            model_reset();
            return;
        end
        np = m_phase;
        m_run_start = 0;
        m_proc_end  = 0;
        case (m_phase)
            0: if (rx_done) begin np = 1; m_last_rx = cyc; m_wdog_err = 0; end
            1: begin
                if (abort) np = 4;
                else if (rx_done) m_last_rx = cyc;
                else if (cyc - m_last_rx == longint'(LT)) begin
                    np = 2; m_load_done = 1; m_job_start = cyc + 1;
                end
            end
            2, 3: begin
                wd = (cyc - m_job_start + 1) >= longint'(WD);
                if (m_phase == 2) m_frame = ram_douta;
                else begin
                    m_gen = ram_douta;
                    m_got = m_got | {ccd_done, acq_done, da_done};
                end
                if (wd) m_wdog_err = 1;
                if (abort || wd) np = 4;
                else if (m_phase == 2 && frame_done) begin np = 3; m_run_start = 1; end
                else if (m_phase == 3 && m_got == 3'b111) np = 4;
            end
            default: begin np = 0; m_load_done = 0; m_got = '0; end
        endcase
        if (np == 4 && m_phase != 4) m_proc_end = 1;
        m_phase = np;
    endtask

    task automatic check_all();
        logic [AW-1:0] ea;
        logic          ew;
        ew = 1'b0;
        ea = wr_addr;
        if (!sys_rst_n) ea = '0;
        else begin
            case (m_phase)
                0, 1: ew = wr_en;
                2:    ea = frame_addr;
                3:    ea = gen_addr;
                default: ;
            endcase
        end
        chk("phase", 32'(phase), 32'(m_phase));
        chk("ram_we", 32'(ram_we), 32'(ew));
        chk("ram_addra", 32'(ram_addra), 32'(ea));
        chk("frame_rdata", 32'(frame_rdata), 32'(m_frame));
        chk("gen_rdata", 32'(gen_rdata), 32'(m_gen));
        chk("load_done", 32'(load_done), 32'(m_load_done));
        chk("run_start", 32'(run_start), 32'(m_run_start));
        chk("proc_end", 32'(proc_end), 32'(m_proc_end));
        chk("wdog_err", 32'(wdog_err), 32'(m_wdog_err));
    endtask

    task automatic rand_data();
        if (!hold_data) begin
            wr_en      = 1'($urandom_range(0, 1));
            wr_addr    = AW'($urandom);
            frame_addr = AW'($urandom);
            gen_addr   = AW'($urandom);
            ram_douta  = DW'($urandom);
        end
    endtask

    // Called just after a falling edge; pulse inputs set by the caller last one cycle.
    task automatic tick();
        #1;
        check_all();
        @(posedge sys_clk);
        model_step();
        @(negedge sys_clk);
        rx_done = 0; frame_done = 0; da_done = 0; acq_done = 0; ccd_done = 0; abort = 0;
        rand_data();
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_load(input int npulses, input int gap);
        int n;
        for (int i = 0; i < npulses; i++) begin
            if (i > 0) run_ticks(gap - 1);
            rx_done = 1;
            tick();
            if (i == 0) chk("load_wdog_clr", 32'(wdog_err), 0);
        end
        n = 0;
        while (load_done !== 1'b1 && n < int'(LT) + 20) begin
            tick();
            n++;
        end
        chk("load_lat", 32'(n), LT);
    endtask

    task automatic rand_job();
        int n;
        do_load(int'($urandom_range(1, 5)), int'($urandom_range(2, 300)));
        n = 0;
        while (m_phase != 0 && n < 1500) begin
            rx_done    = ($urandom_range(0, 7) == 0);
            abort      = ($urandom_range(0, 199) == 0);
            frame_done = ($urandom_range(0, 15) == 0);
            da_done    = ($urandom_range(0, 9) == 0);
            acq_done   = ($urandom_range(0, 9) == 0);
            ccd_done   = ($urandom_range(0, 9) == 0);
            tick();
            n++;
        end
        chk("rand_job_end", 32'(phase), 0);
    endtask

    task automatic load_abort_job();
        abort = 1;
        tick();
        chk("idle_abort_phase", 32'(phase), 0);
        chk("idle_abort_pe", 32'(proc_end), 0);
        rx_done = 1;
        tick();
        for (int i = 0; i < int'($urandom_range(0, 100)); i++) begin
            rx_done = ($urandom_range(0, 3) == 0);
            tick();
        end
        abort = 1;
        rx_done = 1'($urandom_range(0, 1));
        tick();
        chk("ld_abort_phase", 32'(phase), 4);
        chk("ld_abort_pe", 32'(proc_end), 1);
        tick();
        chk("ld_abort_idle", 32'(phase), 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL global_timeout got=%0d exp=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        model_reset();
        rand_data();
        #2;
        check_all();
        @(negedge sys_clk);
        run_ticks(2);
        sys_rst_n = 1;
        tick();

        // Directed job: load timing, parse datapath, run completion.
        do_load(5, 100);
        hold_data = 1;
        frame_addr = 14'h0010; wr_en = 1; ram_douta = 16'hBEEF;
        #1;
        chk("parse_addr", 32'(ram_addra), 32'h0010);
        chk("parse_we", 32'(ram_we), 0);
        tick();
        chk("parse_rdata", 32'(frame_rdata), 32'hBEEF);
        hold_data = 0;
        run_ticks(3);
        frame_done = 1;
        tick();
        chk("run_start_hi", 32'(run_start), 1);
        chk("run_phase", 32'(phase), 3);
        tick();
        chk("run_start_lo", 32'(run_start), 0);
        ccd_done = 1;
        tick();
        run_ticks(49);
        da_done = 1; acq_done = 1;
        tick();
        chk("done_phase", 32'(phase), 4);
        chk("proc_end_hi", 32'(proc_end), 1);
        tick();
        chk("idle_phase", 32'(phase), 0);
        chk("proc_end_lo", 32'(proc_end), 0);

        // Watchdog job.
        do_load(1, 2);
        n = 0;
        while (phase != 3'd4 && n < int'(WD) + 20) begin
            if (n == 10) frame_done = 1;
            tick();
            n++;
        end
        chk("wdog_cycles", 32'(n), WD);
        chk("wdog_err_set", 32'(wdog_err), 1);
        chk("wdog_proc_end", 32'(proc_end), 1);
        tick();
        chk("wdog_idle", 32'(phase), 0);
        chk("wdog_sticky", 32'(wdog_err), 1);

        for (int j = 0; j < 4; j++) load_abort_job();

        // Abort coincident with the last generator done.
        do_load(2, int'($urandom_range(2, 50)));
        frame_done = 1;
        tick();
        da_done = 1;
        tick();
        acq_done = 1; da_done = 1;
        tick();
        run_ticks(3);
        ccd_done = 1; abort = 1;
        tick();
        chk("abort_phase", 32'(phase), 4);
        chk("abort_pe", 32'(proc_end), 1);
        tick();
        chk("abort_idle", 32'(phase), 0);
        chk("abort_pe_lo", 32'(proc_end), 0);
        tick();
        chk("abort_pe_once", 32'(proc_end), 0);

        rand_job();
        rand_job();

        // Asynchronous reset in the middle of RUN.
        do_load(1, 2);
        frame_done = 1;
        tick();
        run_ticks(5);
        da_done = 1;
        tick();
        #2 sys_rst_n = 0;
        #1;
        chk("rst_phase", 32'(phase), 0);
        chk("rst_pe", 32'(proc_end), 0);
        chk("rst_ld", 32'(load_done), 0);
        chk("rst_rs", 32'(run_start), 0);
        chk("rst_we", 32'(ram_we), 0);
        chk("rst_addr", 32'(ram_addra), 0);
        chk("rst_gen", 32'(gen_rdata), 0);
        chk("rst_frame", 32'(frame_rdata), 0);
        chk("rst_wdog", 32'(wdog_err), 0);
        model_reset();
        run_ticks(2);
        sys_rst_n = 1;
        run_ticks(5);

        rand_job();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
